micro_write_bus: RTL and testbench
==================================

# micro_write_bus

Parametrised, arbitrated write bus for the micro-CPU datapath. Multiple producers (immediate decoder, ALU result, PC/branch-target logic, register-file read path) compete for one shared write bus. A round-robin arbiter grants one beat per cycle, registers it onto the bus, and commits it into a bank of micro registers with a combinational read port. It replaces the single-source, mux-only write bus with a handshaked, multi-channel, registered one.

## Interface
- `NUM_SRC`, default 4: number of source channels, 2..8.
- `DATA_W`, default 8: data width.
- `NUM_MREG`, default 8: number of micro registers, 2..16.
- `SRC_W` = `$clog2(NUM_SRC)` and `MREG_W` = `$clog2(NUM_MREG)` are derived localparams and are not overridable.
- `clk` in 1: the single clock; everything is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `src_valid` in NUM_SRC: per-channel beat request.
- `src_ready` out NUM_SRC: per-channel grant; a beat transfers when valid & ready.
- `src_data` in NUM_SRC*DATA_W: packed, channel i at [i*DATA_W +: DATA_W].
- `src_dst` in NUM_SRC*MREG_W: packed micro-register index per channel.
- `src_lock` in NUM_SRC: present only with `WBUS_LOCK_EN`.
- `bus_valid` out 1: a registered beat is on the bus this cycle.
- `bus_src` out SRC_W: channel that produced the beat.
- `bus_dst` out MREG_W: destination index of the beat.
- `bus_data` out DATA_W: beat data.
- `bus_err` out 1: the beat's dst was >= NUM_MREG, so no write occurred.
- `rd_addr` in MREG_W: micro-register read index.
- `rd_data` out DATA_W: combinational read of mreg[rd_addr]; returns 0 when out of range.

## Operation
- Eligible set: every i with `src_valid[i]`.
- Arbitration: round-robin. Search starts at `ptr+1` modulo NUM_SRC; the first eligible channel wins.
- `src_ready` is one-hot or all-zero, and is combinational from `src_valid` and state only.
- `ptr` updates to the granted index on every transfer and is held otherwise.
- A source must hold data, dst and lock stable, and keep valid high, until ready.
- On a transfer the beat is registered to `bus_*` at the next edge, and `mreg[dst]` is written at that same edge.
- Out-of-range dst: the beat still appears on the bus with `bus_err`=1, and no register is written.
- No bypass. A read of a register that is being written returns the old value in the cycle of the write edge; the new value is visible from the following cycle.
- Reset values:
  - `ptr` = NUM_SRC-1, so channel 0 has first priority.
  - All mregs = 0.
  - `bus_valid`, `bus_src`, `bus_dst`, `bus_data`, `bus_err` = 0.
  - Lock state clear.

## Timing
- Latency 1 cycle: the beat transfers in cycle N and `bus_valid` is high in cycle N+1.
- Throughput is one beat per cycle with no bubbles. A channel that is the sole requester is granted every cycle.
- `bus_valid` is high for exactly one cycle per beat and low in idle cycles. The other bus outputs hold their last value when idle.
- Fairness: any channel holding valid is granted within NUM_SRC cycles (without lock).
- Reset asserted mid-operation: all outputs and state clear immediately, and any in-flight beat is dropped. The first grant after release goes to channel 0.

## Configuration
- `WBUS_LOCK_EN` defined:
  - `src_lock` port exists.
  - A transfer with lock=1 locks the arbiter to that channel. Only that channel is eligible until it transfers a beat with lock=0.
  - While locked and the owner's valid is low, no grant is issued and the bus idles.
  - `ptr` still updates to the owner.
- `WBUS_LOCK_EN` undefined: the port is absent and arbitration is pure round-robin.

## Structure
- Package `wbus_pkg` holds:
  - the beat struct typedef {src, dst, data, err};
  - the min/max parameter limits, checked by an elaboration-time assertion.
- Sub-module `rr_arbiter` (params NUM_SRC):
  - inputs `req`, `ptr` (and `lock_req`/`lock_id` under the macro);
  - outputs one-hot `gnt` and `gnt_id`.
- The top level holds the bus registers, the mreg array and the read mux.

## Test plan
- Reset release, then ch0 only, data 0x5A, dst 3. Required: `src_ready[0]` in the same cycle; next cycle `bus_valid`=1, `bus_src`=0, `bus_data`=0x5A; `rd_addr`=3 reads 0x5A one cycle later.
- All 4 channels held valid for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3 with `bus_valid` continuous.
- Ch1 writes 0x11 to mreg2 while `rd_addr`=2 in the commit cycle. Required: `rd_data` reads the old value 0x00 at that edge, then 0x11.
- NUM_MREG=6, dst=7, data 0xFF. Required: `bus_err`=1 and no mreg changed.
- `WBUS_LOCK_EN`: ch2 sends 3 beats with lock=1,1,0 while ch0 requests continuously. Required: bus shows ch2 ×3, then ch0 gets the next grant.
- `rst_n` pulled low while ch3 has a beat pending. Required: outputs read 0 during reset; after release the first grant goes to ch0.

Source files
------------

// File: rtl/wbus_pkg.sv
// Shared types and parameter limits for the micro-CPU write bus.
//   wbus_beat_t    : one registered bus beat {src, dst, data, err}, fields
//                    sized for the largest legal configuration.
//   wbus_params_ok : elaboration-time range check for the top parameters.
package wbus_pkg;

  localparam int unsigned NUM_SRC_MIN  = 2;
  localparam int unsigned NUM_SRC_MAX  = 8;
  localparam int unsigned NUM_MREG_MIN = 2;
  localparam int unsigned NUM_MREG_MAX = 16;
  localparam int unsigned DATA_W_MIN   = 1;
  localparam int unsigned DATA_W_MAX   = 32;

  localparam int unsigned SRC_W_MAX  = $clog2(NUM_SRC_MAX);
  localparam int unsigned MREG_W_MAX = $clog2(NUM_MREG_MAX);

  typedef struct packed {
    logic [SRC_W_MAX-1:0]  src;
    logic [MREG_W_MAX-1:0] dst;
    logic [DATA_W_MAX-1:0] data;
    logic                  err;
  } wbus_beat_t;

  function automatic bit wbus_params_ok(input int unsigned num_src,
                                        input int unsigned data_w,
                                        input int unsigned num_mreg);
    return (num_src  >= NUM_SRC_MIN)  && (num_src  <= NUM_SRC_MAX)  &&
           (data_w   >= DATA_W_MIN)   && (data_w   <= DATA_W_MAX)   &&
           (num_mreg >= NUM_MREG_MIN) && (num_mreg <= NUM_MREG_MAX);
  endfunction

endpackage

// File: rtl/micro_write_bus_rr_arbiter.sv
// Round-robin arbiter for the micro write bus.
//   req      : per-channel request
//   ptr      : last granted channel; the search starts at ptr+1
//   lock_req : (WBUS_LOCK_EN only) arbiter is locked to lock_id
//   lock_id  : (WBUS_LOCK_EN only) locked owner channel
//   gnt      : one-hot grant, all-zero when nothing is eligible
//   gnt_id   : binary index of the granted channel (0 when no grant)
// Optional feature macro: WBUS_LOCK_EN.
module rr_arbiter
  import wbus_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
`ifdef WBUS_LOCK_EN
  input  logic               lock_req,
  input  logic [SRC_W-1:0]   lock_id,
`endif
  output logic [NUM_SRC-1:0] gnt,
  output logic [SRC_W-1:0]   gnt_id
);

  logic [NUM_SRC-1:0] req_eff;
  logic               found;
  int unsigned        idx;

  // Rotating priority search from ptr+1; first eligible channel wins.
  always_comb begin
    req_eff = req;
    found   = 1'b0;
    idx     = 0;
    gnt_id  = '0;
`ifdef WBUS_LOCK_EN
    if (lock_req) begin
      req_eff = req & (NUM_SRC'(1) << lock_id);
    end
`endif
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(ptr) + k) % NUM_SRC;
      if (!found && req_eff[SRC_W'(idx)]) begin
        found  = 1'b1;
        gnt_id = SRC_W'(idx);
      end
    end
    gnt = found ? (NUM_SRC'(1) << gnt_id) : '0;
  end

endmodule

// File: rtl/micro_write_bus.sv
// Arbitrated, registered write bus for the micro-CPU datapath.
// Producers request beats on src_*; one beat per cycle is granted round-robin,
// registered onto bus_* and committed into a micro-register bank at the same
// edge. The bank has a combinational, non-bypassed read port.
//   clk, rst_n           : clock, asynchronous active-low reset
//   src_valid/src_ready  : per-channel handshake (ready is combinational)
//   src_data, src_dst    : packed per-channel payload and destination index
//   src_lock             : per-channel lock request (WBUS_LOCK_EN only)
//   bus_valid/src/dst/data/err : registered beat; err flags dst >= NUM_MREG
//   rd_addr, rd_data     : combinational micro-register read, 0 if out of range
// Optional feature macro: WBUS_LOCK_EN (lockable arbitration).
module micro_write_bus
  import wbus_pkg::*;
#(
  parameter  int unsigned NUM_SRC  = 4,
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned NUM_MREG = 8,
  localparam int unsigned SRC_W    = $clog2(NUM_SRC),
  localparam int unsigned MREG_W   = $clog2(NUM_MREG)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  input  logic [NUM_SRC*MREG_W-1:0]  src_dst,
`ifdef WBUS_LOCK_EN
  input  logic [NUM_SRC-1:0]         src_lock,
`endif
  output logic                       bus_valid,
  output logic [SRC_W-1:0]           bus_src,
  output logic [MREG_W-1:0]          bus_dst,
  output logic [DATA_W-1:0]          bus_data,
  output logic                       bus_err,
  input  logic [MREG_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  if (!wbus_params_ok(NUM_SRC, DATA_W, NUM_MREG)) begin : g_param_check
    $error("micro_write_bus: NUM_SRC, DATA_W or NUM_MREG out of range");
  end

  localparam logic [MREG_W:0] NUM_MREG_L = (MREG_W+1)'(NUM_MREG);

  logic [NUM_SRC-1:0]  gnt;
  logic [SRC_W-1:0]    gnt_id;
  logic                xfer;

  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic                bus_valid_q, bus_valid_d;
  wbus_beat_t          beat_q, beat_d;
  logic [DATA_W-1:0]   mreg_q [NUM_MREG];
  logic [DATA_W-1:0]   mreg_d [NUM_MREG];

  logic [DATA_W-1:0]   data_a [NUM_SRC];
  logic [MREG_W-1:0]   dst_a  [NUM_SRC];
  logic [DATA_W-1:0]   sel_data;
  logic [MREG_W-1:0]   sel_dst;
  logic                sel_err;

`ifdef WBUS_LOCK_EN
  logic                lock_q, lock_d;
  logic [SRC_W-1:0]    lock_id_q, lock_id_d;
`endif

  // Unpack the flat per-channel payload buses.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      data_a[i] = src_data[i*DATA_W +: DATA_W];
      dst_a[i]  = src_dst[i*MREG_W +: MREG_W];
    end
  end

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .req      (src_valid),
    .ptr      (ptr_q),
`ifdef WBUS_LOCK_EN
    .lock_req (lock_q),
    .lock_id  (lock_id_q),
`endif
    .gnt      (gnt),
    .gnt_id   (gnt_id)
  );

  assign src_ready = gnt;

  // Next state: capture the granted beat and commit it unless dst is out of range.
  always_comb begin
    xfer        = |gnt;
    sel_data    = data_a[gnt_id];
    sel_dst     = dst_a[gnt_id];
    sel_err     = ({1'b0, sel_dst} >= NUM_MREG_L);
    ptr_d       = ptr_q;
    bus_valid_d = xfer;
    beat_d      = beat_q;
    mreg_d      = mreg_q;
`ifdef WBUS_LOCK_EN
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
`endif
    if (xfer) begin
      ptr_d       = gnt_id;
      beat_d.src  = SRC_W_MAX'(gnt_id);
      beat_d.dst  = MREG_W_MAX'(sel_dst);
      beat_d.data = DATA_W_MAX'(sel_data);
      beat_d.err  = sel_err;
      if (!sel_err) begin
        mreg_d[sel_dst] = sel_data;
      end
`ifdef WBUS_LOCK_EN
      // Lock state follows the lock bit of the owner's most recent beat.
      lock_d    = src_lock[gnt_id];
      lock_id_d = gnt_id;
`endif
    end
  end

  // State registers; reset drops any in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= SRC_W'(NUM_SRC - 1);
      bus_valid_q <= 1'b0;
      beat_q      <= '0;
      for (int unsigned i = 0; i < NUM_MREG; i++) begin
        mreg_q[i] <= '0;
      end
`ifdef WBUS_LOCK_EN
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      bus_valid_q <= bus_valid_d;
      beat_q      <= beat_d;
      mreg_q      <= mreg_d;
`ifdef WBUS_LOCK_EN
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
`endif
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_src   = beat_q.src[SRC_W-1:0];
  assign bus_dst   = beat_q.dst[MREG_W-1:0];
  assign bus_data  = beat_q.data[DATA_W-1:0];
  assign bus_err   = beat_q.err;

  // The beat struct is sized for the largest configuration; upper bits are spare.
  logic unused_beat_bits;
  assign unused_beat_bits = ^beat_q;

  // Combinational read port, no write bypass.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < NUM_MREG_L) begin
      rd_data = mreg_q[rd_addr];
    end
  end

endmodule

// File: tb/tb_micro_write_bus.sv
module tb_micro_write_bus;

  logic        clk;
  logic        rst_n;
  logic [3:0]  src_valid;
  logic [3:0]  src_ready;
  logic [31:0] src_data;
  logic [11:0] src_dst;
`ifdef WBUS_LOCK_EN
  logic [3:0]  src_lock;
`endif
  logic        bus_valid;
  logic [1:0]  bus_src;
  logic [2:0]  bus_dst;
  logic [7:0]  bus_data;
  logic        bus_err;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;

  // second instance with a non power-of-two register bank
  logic [3:0]  v6, r6;
  logic [31:0] d6;
  logic [11:0] dst6;
`ifdef WBUS_LOCK_EN
  logic [3:0]  lk6;
`endif
  logic        bv6, be6;
  logic [1:0]  bs6;
  logic [2:0]  bd6, rd6;
  logic [7:0]  bdat6, rdd6;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         ptr_m;
  bit         lock_m;
  int         lock_id_m;
  logic [7:0] mreg_m [8];
  logic       eb_valid;
  logic [1:0] eb_src;
  logic [2:0] eb_dst;
  logic [7:0] eb_data;
  logic       eb_err;

  micro_write_bus #(.NUM_SRC(4), .DATA_W(8), .NUM_MREG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .src_dst(src_dst),
`ifdef WBUS_LOCK_EN
    .src_lock(src_lock),
`endif
    .bus_valid(bus_valid), .bus_src(bus_src), .bus_dst(bus_dst),
    .bus_data(bus_data), .bus_err(bus_err),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  micro_write_bus #(.NUM_SRC(4), .DATA_W(8), .NUM_MREG(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .src_valid(v6), .src_ready(r6),
    .src_data(d6), .src_dst(dst6),
`ifdef WBUS_LOCK_EN
    .src_lock(lk6),
`endif
    .bus_valid(bv6), .bus_src(bs6), .bus_dst(bd6),
    .bus_data(bdat6), .bus_err(be6),
    .rd_addr(rd6), .rd_data(rdd6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    ptr_m = 3; lock_m = 0; lock_id_m = 0;
    for (int i = 0; i < 8; i++) mreg_m[i] = 8'h00;
    eb_valid = 0; eb_src = 0; eb_dst = 0; eb_data = 0; eb_err = 0;
  endtask

  // Winner is the first requesting channel after the last winner, cyclically.
  function automatic int model_pick(input logic [3:0] v);
    if (lock_m) return v[lock_id_m] ? lock_id_m : -1;
    for (int k = 1; k <= 4; k++) begin
      if (v[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_commit(input int g);
    if (g < 0) begin
      eb_valid = 0;
      return;
    end
    eb_valid = 1;
    eb_src   = 2'(g);
    eb_dst   = src_dst[g*3 +: 3];
    eb_data  = src_data[g*8 +: 8];
    eb_err   = 0;
    mreg_m[eb_dst] = eb_data;
    ptr_m = g;
`ifdef WBUS_LOCK_EN
    lock_m = src_lock[g];
    lock_id_m = g;
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_ch(input int i, input logic v, input logic [7:0] d,
                        input logic [2:0] dst, input logic lk);
    src_valid[i]       = v;
    src_data[i*8 +: 8] = d;
    src_dst[i*3 +: 3]  = dst;
`ifdef WBUS_LOCK_EN
    src_lock[i]        = lk;
`else
    if (lk) begin end
`endif
  endtask

  task automatic clear_inputs();
    src_valid = 0; src_data = 0; src_dst = 0; rd_addr = 0;
    v6 = 0; d6 = 0; dst6 = 0; rd6 = 0;
`ifdef WBUS_LOCK_EN
    src_lock = 0; lk6 = 0;
`endif
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_valid, bus_src, bus_dst, bus_data, bus_err} !== 15'h0) begin
      errors++;
      $display("FAIL reset_bus got=%h exp=0", {bus_valid, bus_src, bus_dst, bus_data, bus_err});
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      checks++;
      if (rd_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_mreg addr=%0d got=%h exp=00", a, rd_data);
      end
    end
    rd_addr = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    set_ch(0, 1'b1, 8'h5A, 3'd3, 1'b0);
    @(negedge clk);
    checks++;
    if (src_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready got=%b exp=0001", src_ready);
    end
    model_commit(model_pick(src_valid));
    next_cycle();
    src_valid = 0;
    rd_addr   = 3'd3;
    @(negedge clk);
    checks++;
    if ({bus_valid, bus_src, bus_dst, bus_data, bus_err} !== {1'b1, 2'd0, 3'd3, 8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL single_bus got=%b/%0d/%0d/%h/%b exp=1/0/3/5a/0",
               bus_valid, bus_src, bus_dst, bus_data, bus_err);
    end
    checks++;
    if (rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL single_rd got=%h exp=5a", rd_data);
    end
    model_commit(-1);
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus_valid !== 1'b0 || bus_data !== 8'h5A) begin
      errors++;
      $display("FAIL single_idle got=%b/%h exp=0/5a", bus_valid, bus_data);
    end
  endtask

  task automatic test_round_robin();
    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int g;
    apply_reset();
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 8'(8'h10 + i), 3'(4 + i), 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (src_ready !== 4'(1 << order[k])) begin
        errors++;
        $display("FAIL rr_ready k=%0d got=%b exp=%b", k, src_ready, 4'(1 << order[k]));
      end
      if (k > 0) begin
        checks++;
        if (bus_valid !== 1'b1 || bus_src !== 2'(order[k-1])) begin
          errors++;
          $display("FAIL rr_bus k=%0d got=%b/%0d exp=1/%0d", k, bus_valid, bus_src, order[k-1]);
        end
      end
      g = model_pick(src_valid);
      model_commit(g);
      next_cycle();
      if (g >= 0) src_data[g*8 +: 8] = 8'($urandom);
    end
    src_valid = 0;
    @(negedge clk);
    checks++;
    if ({bus_valid, bus_src, bus_dst, bus_data} !== {eb_valid, eb_src, eb_dst, eb_data}) begin
      errors++;
      $display("FAIL rr_last got=%b/%0d/%0d/%h exp=%b/%0d/%0d/%h", bus_valid, bus_src,
               bus_dst, bus_data, eb_valid, eb_src, eb_dst, eb_data);
    end
    model_commit(-1);
    next_cycle();
  endtask

  task automatic test_no_bypass();
    apply_reset();
    set_ch(1, 1'b1, 8'h11, 3'd2, 1'b0);
    rd_addr = 3'd2;
    @(negedge clk);
    checks++;
    if (src_ready !== 4'b0010 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL nobypass_old got=%b/%h exp=0010/00", src_ready, rd_data);
    end
    model_commit(model_pick(src_valid));
    next_cycle();
    src_valid = 0;
    @(negedge clk);
    checks++;
    if (rd_data !== 8'h11) begin
      errors++;
      $display("FAIL nobypass_new got=%h exp=11", rd_data);
    end
    model_commit(-1);
    next_cycle();
  endtask

  task automatic test_bad_dst();
    logic [7:0] exp6;
    apply_reset();
    // last legal register first, then two out-of-range indices
    v6[0] = 1'b1; d6[7:0] = 8'h33; dst6[2:0] = 3'd5;
    next_cycle();
    d6[7:0] = 8'hFF; dst6[2:0] = 3'd7;
    @(negedge clk);
    checks++;
    if (bv6 !== 1'b1 || be6 !== 1'b0 || bd6 !== 3'd5) begin
      errors++;
      $display("FAIL baddst_legal got=%b/%b/%0d exp=1/0/5", bv6, be6, bd6);
    end
    next_cycle();
    d6[7:0] = 8'hEE; dst6[2:0] = 3'd6;
    @(negedge clk);
    checks++;
    if ({bv6, bd6, bdat6, be6} !== {1'b1, 3'd7, 8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL baddst_7 got=%b/%0d/%h/%b exp=1/7/ff/1", bv6, bd6, bdat6, be6);
    end
    next_cycle();
    v6 = 0;
    @(negedge clk);
    checks++;
    if ({bv6, bd6, bdat6, be6} !== {1'b1, 3'd6, 8'hEE, 1'b1}) begin
      errors++;
      $display("FAIL baddst_6 got=%b/%0d/%h/%b exp=1/6/ee/1", bv6, bd6, bdat6, be6);
    end
    for (int a = 0; a < 8; a++) begin
      rd6 = 3'(a);
      #1;
      exp6 = (a == 5) ? 8'h33 : 8'h00;
      checks++;
      if (rdd6 !== exp6) begin
        errors++;
        $display("FAIL baddst_mreg addr=%0d got=%h exp=%h", a, rdd6, exp6);
      end
    end
    next_cycle();
  endtask

`ifdef WBUS_LOCK_EN
  task automatic test_lock();
    logic [3:0] exp_r [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
    logic [1:0] exp_s [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
    apply_reset();
    set_ch(2, 1'b1, 8'hA0, 3'd1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (src_ready !== exp_r[k]) begin
        errors++;
        $display("FAIL lock_ready k=%0d got=%b exp=%b", k, src_ready, exp_r[k]);
      end
      if (k > 0) begin
        checks++;
        if (bus_valid !== 1'b1 || bus_src !== exp_s[k-1]) begin
          errors++;
          $display("FAIL lock_bus k=%0d got=%b/%0d exp=1/%0d", k, bus_valid, bus_src, exp_s[k-1]);
        end
      end
      model_commit(model_pick(src_valid));
      next_cycle();
      set_ch(0, 1'b1, 8'(8'hC0 + k), 3'd0, 1'b0);
      set_ch(2, k < 2, 8'(8'hA1 + k), 3'd1, k < 1);
    end
    // owner idles while locked: nobody is granted
    clear_inputs();
    set_ch(1, 1'b1, 8'hB1, 3'd6, 1'b1);
    @(negedge clk);
    model_commit(model_pick(src_valid));
    next_cycle();
    set_ch(1, 1'b0, 8'hB1, 3'd6, 1'b1);
    set_ch(0, 1'b1, 8'hC9, 3'd7, 1'b0);
    @(negedge clk);
    checks++;
    if (src_ready !== 4'b0000) begin
      errors++;
      $display("FAIL lock_idle_ready got=%b exp=0000", src_ready);
    end
    model_commit(model_pick(src_valid));
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL lock_idle_bus got=%b exp=0", bus_valid);
    end
    model_commit(model_pick(src_valid));
    next_cycle();
    clear_inputs();
  endtask
`endif

  task automatic test_reset_midop();
    apply_reset();
    set_ch(0, 1'b1, 8'h70, 3'd4, 1'b0);
    set_ch(1, 1'b1, 8'h71, 3'd5, 1'b0);
    set_ch(3, 1'b1, 8'h73, 3'd6, 1'b0);
    @(negedge clk);
    checks++;
    if (src_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_first got=%b exp=0001", src_ready);
    end
    model_commit(model_pick(src_valid));
    next_cycle();
    src_data[7:0] = 8'h80;
    rd_addr = 3'd4;
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus_valid, bus_src, bus_dst, bus_data, bus_err} !== 15'h0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL midrst_clear got=%h/%h exp=0/00",
               {bus_valid, bus_src, bus_dst, bus_data, bus_err}, rd_data);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_valid !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL midrst_hold got=%b/%h exp=0/00", bus_valid, rd_data);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (src_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_after got=%b exp=0001", src_ready);
    end
    model_commit(model_pick(src_valid));
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    bit pending [4];
    int waited [4];
    int g;
    logic [3:0] exp_r;
    logic [7:0] exp_rd;
    apply_reset();
    for (int i = 0; i < 4; i++) begin pending[i] = 0; waited[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pending[i]) begin
          set_ch(i, $urandom_range(0, 99) < 60, 8'($urandom), 3'($urandom),
                 $urandom_range(0, 3) == 0);
        end
      end
      rd_addr = 3'($urandom);
      @(negedge clk);
      g = model_pick(src_valid);
      exp_r = (g >= 0) ? 4'(1 << g) : 4'b0000;
      exp_rd = mreg_m[rd_addr];
      checks++;
      if (src_ready !== exp_r) begin
        errors++;
        $display("FAIL rand_ready c=%0d got=%b exp=%b", c, src_ready, exp_r);
      end
      checks++;
      if ({bus_valid, bus_src, bus_dst, bus_data, bus_err} !==
          {eb_valid, eb_src, eb_dst, eb_data, eb_err}) begin
        errors++;
        $display("FAIL rand_bus c=%0d got=%b/%0d/%0d/%h/%b exp=%b/%0d/%0d/%h/%b", c,
                 bus_valid, bus_src, bus_dst, bus_data, bus_err,
                 eb_valid, eb_src, eb_dst, eb_data, eb_err);
      end
      checks++;
      if (rd_data !== exp_rd) begin
        errors++;
        $display("FAIL rand_rd c=%0d addr=%0d got=%h exp=%h", c, rd_addr, rd_data, exp_rd);
      end
`ifndef WBUS_LOCK_EN
      if (g >= 0) begin
        checks++;
        if (waited[g] > 3) begin
          errors++;
          $display("FAIL rand_fair c=%0d ch=%0d got=%0d exp<=3", c, g, waited[g]);
        end
      end
`endif
      for (int i = 0; i < 4; i++) begin
        pending[i] = src_valid[i] && (g != i);
        waited[i]  = pending[i] ? waited[i] + 1 : 0;
      end
      model_commit(g);
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_no_bypass();
    test_bad_dst();
`ifdef WBUS_LOCK_EN
    test_lock();
`endif
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
